// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared state encoding, defaults and clog2 helper for the rx BER path
package rx_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } ber_state_e;

    // Defaults shared with the TX PRBS source and the FIR top level
    localparam int OS_DEF      = 4;
    localparam int WINDOW_DEF  = 128;
    localparam int ERR_THR_DEF = 8;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/symbol_slicer.sv
// rtl/symbol_slicer.sv - decimates the oversampled FIR output at a phase and hard-slices it
module symbol_slicer
    import rx_pkg::*;
#(
    parameter int NB_IN    = 18,
    parameter int OS       = OS_DEF,
    parameter int NB_PHASE = clog2(OS)
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic signed [NB_IN-1:0] i_sample,
    input  logic [NB_PHASE-1:0]     i_phase,
    output logic                    o_dec,
    output logic                    o_dec_bit,
    output logic                    o_rx_bit,
    output logic                    o_rx_valid
);

    logic [NB_PHASE-1:0] ph_cnt_q;
    logic [NB_PHASE-1:0] ph_cnt_d;
    logic                rx_bit_q;
    logic                rx_valid_q;

    assign o_dec     = i_en && (ph_cnt_q == i_phase);
    // Non-negative samples slice to 1; equivalent to inverting the sign bit
    assign o_dec_bit = (i_sample >= $signed({NB_IN{1'b0}}));

    always_comb begin
        ph_cnt_d = ph_cnt_q;
        if (i_en) begin
            if (ph_cnt_q == NB_PHASE'(OS - 1)) begin
                ph_cnt_d = '0;
            end else begin
                ph_cnt_d = ph_cnt_q + NB_PHASE'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            ph_cnt_q   <= '0;
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            ph_cnt_q   <= ph_cnt_d;
            rx_valid_q <= o_dec;
            if (o_dec) begin
                rx_bit_q <= o_dec_bit;
            end
        end
    end

    assign o_rx_bit   = rx_bit_q;
    assign o_rx_valid = rx_valid_q;

endmodule

// File: rtl/rx_ber_checker.sv
// rtl/rx_ber_checker.sv - loopback latency search and BER counting against the TX PRBS stream
module rx_ber_checker
    import rx_pkg::*;
#(
    parameter int NB_IN    = 18,
    parameter int OS       = OS_DEF,
    parameter int NB_PHASE = clog2(OS),
    parameter int MAX_LAT  = 512,
    parameter int NB_LAT   = clog2(MAX_LAT),
    parameter int WINDOW   = WINDOW_DEF,
    parameter int ERR_THR  = ERR_THR_DEF,
    parameter int NB_CNT   = 64
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic signed [NB_IN-1:0] i_sample,
    input  logic [NB_PHASE-1:0]     i_phase,
    input  logic                    i_ref_valid,
    input  logic                    i_ref_bit,
    input  logic                    i_clear,
    output logic                    o_rx_bit,
    output logic                    o_rx_valid,
    output logic                    o_lock,
    output logic [NB_LAT-1:0]       o_latency,
    output logic [NB_CNT-1:0]       o_bit_count,
    output logic [NB_CNT-1:0]       o_err_count
);

    localparam int NB_WIN = clog2(WINDOW + 1);

    logic                dec;
    logic                dec_bit;
    logic [MAX_LAT-1:0]  ref_q;
    ber_state_e          state_q;
    logic                lock_q;
    logic [NB_LAT-1:0]   lat_q;
    logic [NB_WIN-1:0]   win_cnt_q;
    logic [NB_WIN-1:0]   win_err_q;
    logic [NB_CNT-1:0]   bit_cnt_q;
    logic [NB_CNT-1:0]   err_cnt_q;
    logic                mismatch;
    logic                win_end;
    logic [NB_WIN-1:0]   win_err_tot;
    logic [NB_LAT-1:0]   lat_next;

    symbol_slicer #(
        .NB_IN    (NB_IN),
        .OS       (OS),
        .NB_PHASE (NB_PHASE)
    ) u_slicer (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_en       (i_en),
        .i_sample   (i_sample),
        .i_phase    (i_phase),
        .o_dec      (dec),
        .o_dec_bit  (dec_bit),
        .o_rx_bit   (o_rx_bit),
        .o_rx_valid (o_rx_valid)
    );

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            ref_q <= '0;
        end else if (i_ref_valid) begin
            ref_q <= {ref_q[MAX_LAT-2:0], i_ref_bit};
        end
    end

    // Compare against the tap as held before any same-cycle shift
    assign mismatch    = dec_bit ^ ref_q[lat_q];
    assign win_end     = dec && (win_cnt_q == NB_WIN'(WINDOW - 1));
    assign win_err_tot = win_err_q + NB_WIN'(mismatch);
    assign lat_next    = (lat_q == NB_LAT'(MAX_LAT - 1)) ? '0 : lat_q + NB_LAT'(1);

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= SEARCH;
            lock_q    <= 1'b0;
            lat_q     <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (i_clear) begin
            state_q   <= SEARCH;
            lock_q    <= 1'b0;
            lat_q     <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (dec) begin
            win_cnt_q <= win_end ? '0 : win_cnt_q + NB_WIN'(1);
            win_err_q <= win_end ? '0 : win_err_tot;
            case (state_q)
                SEARCH: begin
                    if (win_end) begin
                        if (win_err_tot == '0) begin
                            state_q <= LOCK;
                            lock_q  <= 1'b1;
                        end else begin
                            lat_q <= lat_next;
                        end
                    end
                end
                LOCK: begin
                    if (!(&bit_cnt_q)) begin
                        bit_cnt_q <= bit_cnt_q + NB_CNT'(1);
                    end
                    if (mismatch && !(&err_cnt_q)) begin
                        err_cnt_q <= err_cnt_q + NB_CNT'(1);
                    end
                    // Counters are left untouched on loss of lock
                    if (win_end && (win_err_tot > NB_WIN'(ERR_THR))) begin
                        state_q <= SEARCH;
                        lock_q  <= 1'b0;
                        lat_q   <= lat_next;
                    end
                end
                default: begin
                    state_q <= SEARCH;
                    lock_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_lock      = lock_q;
    assign o_latency   = lat_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_rx_ber_checker.sv
// tb/tb_rx_ber_checker.sv - randomized PRBS loopback bench for rx_ber_checker
module tb_rx_ber_checker;

    localparam int NB_IN    = 18;
    localparam int OS       = 4;
    localparam int NB_PHASE = 2;
    localparam int MAX_LAT  = 64;
    localparam int NB_LAT   = 6;
    localparam int WINDOW   = 32;
    localparam int ERR_THR  = 8;
    localparam int DELAY    = 37;
    localparam int PHASE    = 2;

    logic                    clk = 1'b0;
    logic                    i_reset;
    logic                    i_en;
    logic signed [NB_IN-1:0] i_sample;
    logic [NB_PHASE-1:0]     i_phase;
    logic                    i_ref_valid;
    logic                    i_ref_bit;
    logic                    i_clear;

    logic              o_rx_bit, o_rx_valid, o_lock;
    logic [NB_LAT-1:0] o_latency;
    logic [63:0]       o_bit_count, o_err_count;
    logic              s_rx_bit, s_rx_valid, s_lock;
    logic [NB_LAT-1:0] s_latency;
    logic [3:0]        s_bit_count, s_err_count;

    always #5 clk = ~clk;

    rx_ber_checker #(
        .NB_IN(NB_IN), .OS(OS), .NB_PHASE(NB_PHASE), .MAX_LAT(MAX_LAT), .NB_LAT(NB_LAT),
        .WINDOW(WINDOW), .ERR_THR(ERR_THR), .NB_CNT(64)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_sample(i_sample), .i_phase(i_phase),
        .i_ref_valid(i_ref_valid), .i_ref_bit(i_ref_bit), .i_clear(i_clear),
        .o_rx_bit(o_rx_bit), .o_rx_valid(o_rx_valid), .o_lock(o_lock), .o_latency(o_latency),
        .o_bit_count(o_bit_count), .o_err_count(o_err_count)
    );

    rx_ber_checker #(
        .NB_IN(NB_IN), .OS(OS), .NB_PHASE(NB_PHASE), .MAX_LAT(MAX_LAT), .NB_LAT(NB_LAT),
        .WINDOW(WINDOW), .ERR_THR(ERR_THR), .NB_CNT(4)
    ) dut_sat (
        .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_sample(i_sample), .i_phase(i_phase),
        .i_ref_valid(i_ref_valid), .i_ref_bit(i_ref_bit), .i_clear(i_clear),
        .o_rx_bit(s_rx_bit), .o_rx_valid(s_rx_valid), .o_lock(s_lock), .o_latency(s_latency),
        .o_bit_count(s_bit_count), .o_err_count(s_err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: integer counters and a queue of pushed reference bits (index 0 = newest)
    int     m_ph, m_lat, m_wcnt, m_werr;
    bit     m_lock, m_rx_bit, m_rx_valid;
    longint m_bits, m_errs;
    bit     m_ref[$];

    function automatic void model_reset();
        m_ph = 0; m_lat = 0; m_wcnt = 0; m_werr = 0;
        m_lock = 0; m_rx_bit = 0; m_rx_valid = 0;
        m_bits = 0; m_errs = 0;
        m_ref.delete();
        for (int i = 0; i < MAX_LAT; i++) m_ref.push_back(1'b0);
    endfunction

    function automatic void model_step(bit en, logic signed [NB_IN-1:0] smp, bit rv, bit rb, bit clr);
        bit dec, b, mm;
        dec = en && (m_ph == PHASE);
        b   = (smp >= 18'sd0);
        mm  = b ^ m_ref[m_lat];
        m_rx_valid = dec;
        if (dec) m_rx_bit = b;
        if (en) m_ph = (m_ph + 1) % OS;
        if (rv) begin
            m_ref.push_front(rb);
            void'(m_ref.pop_back());
        end
        if (clr) begin
            m_lock = 0; m_lat = 0; m_wcnt = 0; m_werr = 0; m_bits = 0; m_errs = 0;
        end else if (dec) begin
            if (m_lock) begin
                m_bits++;
                m_errs += mm;
            end
            m_wcnt++;
            m_werr += mm;
            if (m_wcnt == WINDOW) begin
                if (!m_lock && m_werr == 0) m_lock = 1;
                else if (!m_lock || m_werr > ERR_THR) begin
                    m_lock = 0;
                    m_lat  = (m_lat + 1) % MAX_LAT;
                end
                m_wcnt = 0;
                m_werr = 0;
            end
        end
    endfunction

    task automatic check_outputs();
        check("rx_valid", o_rx_valid, m_rx_valid);
        check("rx_bit", o_rx_bit, m_rx_bit);
        check("lock", o_lock, m_lock);
        check("latency", o_latency, m_lat);
        check("bit_count", o_bit_count, m_bits);
        check("err_count", o_err_count, m_errs);
        check("sat_bit_count", s_bit_count, (m_bits > 15) ? 15 : m_bits);
        check("sat_err_count", s_err_count, (m_errs > 15) ? 15 : m_errs);
    endtask

    task automatic step(input bit en, input logic signed [NB_IN-1:0] smp, input bit rv, input bit rb, input bit clr);
        @(negedge clk);
        i_en = en; i_sample = smp; i_ref_valid = rv; i_ref_bit = rb; i_clear = clr;
        model_step(en, smp, rv, rb, clr);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    logic [8:0] prbs;
    bit         tx_q[$];
    int         n_sym;

    function automatic bit prbs_next();
        bit fb;
        fb   = prbs[8] ^ prbs[4];
        prbs = {prbs[7:0], fb};
        return fb;
    endfunction

    // Off-centre samples are noise; the centre sample carries the symbol, sometimes exactly 0 / -1
    function automatic logic signed [NB_IN-1:0] eye_sample(bit b, int k);
        logic signed [NB_IN-1:0] v;
        if (k != PHASE) v = NB_IN'($urandom);
        else if ($urandom_range(0, 7) == 0) v = b ? '0 : '1;
        else begin
            v = $signed(NB_IN'($urandom_range(1, 100000)));
            if (!b) v = -v;
        end
        return v;
    endfunction

    task automatic send_symbol(input bit inv, input bit clr);
        bit txb, rxb;
        txb = prbs_next();
        tx_q.push_back(txb);
        rxb = (n_sym >= DELAY) ? tx_q[n_sym - DELAY] : ($urandom_range(0, 1) == 1);
        rxb = rxb ^ inv;
        for (int k = 0; k < OS; k++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, NB_IN'($urandom), 1'b0, 1'b0, 1'b0);
            step(1'b1, eye_sample(rxb, k), k == 0, txb, clr && (k == PHASE));
        end
        n_sym++;
    endtask

    task automatic run_until_lock(input int max_sym);
        for (int i = 0; i < max_sym; i++) begin
            send_symbol(1'b0, 1'b0);
            if (o_lock) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lost;
        int lost_lat;
        i_reset = 1'b0; i_en = 1'b0; i_sample = '0; i_phase = NB_PHASE'(PHASE);
        i_ref_valid = 1'b0; i_ref_bit = 1'b0; i_clear = 1'b0;
        prbs = 9'h1FF; n_sym = 0;
        model_reset();

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_en = ($urandom_range(0, 1) == 1); i_sample = NB_IN'($urandom);
            i_ref_valid = ($urandom_range(0, 1) == 1); i_ref_bit = ($urandom_range(0, 1) == 1);
            i_clear = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
            check_outputs();
        end
        @(negedge clk);
        i_reset = 1'b1; i_en = 1'b0; i_ref_valid = 1'b0; i_clear = 1'b0;

        run_until_lock(40 * WINDOW);
        check("clean_lock", o_lock, 1);
        check("clean_latency", o_latency, 37);
        check("clean_errs", o_err_count, 0);

        send_symbol(1'b1, 1'b0);
        check("single_err", o_err_count, 1);
        for (int i = 0; i < 1000; i++) send_symbol(1'b0, 1'b0);
        check("single_err_after", o_err_count, 1);
        check("single_err_lock", o_lock, 1);

        lost = 0; lost_lat = 0;
        for (int i = 0; i < 64; i++) begin
            send_symbol(i % 2 == 0, 1'b0);
            if (!o_lock && !lost) begin
                lost = 1;
                lost_lat = o_latency;
            end
        end
        check("burst_lost", lost, 1);
        check("burst_latency", lost_lat, 38);
        run_until_lock((MAX_LAT + 2) * WINDOW);
        check("relock_wrap", o_lock, 1);
        check("relock_latency", o_latency, 37);

        send_symbol(1'b0, 1'b1);
        check("clear_lock", o_lock, 0);
        check("clear_latency", o_latency, 0);
        check("clear_bits", o_bit_count, 0);
        check("clear_errs", o_err_count, 0);
        run_until_lock(40 * WINDOW);
        check("clear_relock_latency", o_latency, 37);

        for (int i = 0; i < 200; i++) send_symbol(i % 8 == 0, 1'b0);
        check("sat_err", s_err_count, 15);
        check("sat_bits", s_bit_count, 15);
        check("wide_err", o_err_count, 25);
        check("sat_lock", o_lock, 1);

        @(negedge clk);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_lock", o_lock, 0);
        check("async_latency", o_latency, 0);
        check("async_bits", o_bit_count, 0);
        check("async_errs", o_err_count, 0);
        check("async_rx_valid", o_rx_valid, 0);
        check("async_sat_errs", s_err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_ber_checker.md
Name: rx_ber_checker

Overview:
- Sits directly downstream of the pulse-shaping/matched FIR. Consumes its oversampled signed output at the FIR enable rate.
- Decimates by OS at a selectable phase and hard-slices each kept sample to a bit.
- Finds the loopback latency against the transmitter's PRBS bit stream, then counts received bits and bit errors for BER measurement.

Parameters:
- NB_IN, 18, width of i_sample (signed, matches FIR output width).
- OS, 4, oversampling factor; samples per symbol.
- NB_PHASE, 2, width of i_phase; NB_PHASE = clog2(OS).
- MAX_LAT, 512, depth of the reference delay line; number of candidate latencies.
- NB_LAT, 9, width of o_latency; NB_LAT = clog2(MAX_LAT).
- WINDOW, 128, decisions per search/monitor window.
- ERR_THR, 8, errors in one LOCK window above which lock is dropped.
- NB_CNT, 64, width of the bit and error counters.

Ports:
- clk, in, 1, clock.
- i_reset, in, 1, asynchronous active-low reset.
- i_en, in, 1, sample-rate enable (same strobe that drives the FIR).
- i_sample, in, NB_IN, signed FIR output; valid on cycles where i_en=1.
- i_phase, in, NB_PHASE, decimation phase, 0..OS-1.
- i_ref_valid, in, 1, one pulse per transmitted symbol.
- i_ref_bit, in, 1, transmitted PRBS bit; qualified by i_ref_valid.
- i_clear, in, 1, synchronous restart of search and counters.
- o_rx_bit, out, 1, sliced decision.
- o_rx_valid, out, 1, one-cycle strobe accompanying o_rx_bit.
- o_lock, out, 1, 1 while in LOCK.
- o_latency, out, NB_LAT, current candidate or locked latency, in symbols.
- o_bit_count, out, NB_CNT, bits compared while in LOCK.
- o_err_count, out, NB_CNT, mismatches while in LOCK.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - All outputs are 0.
  - Phase counter, window counters, latency and reference line are 0.
  - FSM enters SEARCH.
- Decimation:
  - ph_cnt increments on each i_en and wraps from OS-1 to 0.
  - Decision strobe dec = i_en && (ph_cnt == i_phase).
  - i_phase is sampled every cycle; a mid-run change takes effect at the next comparison. A symbol may be skipped or duplicated at the switch; this is acceptable.
- Slicer:
  - bit = ~i_sample[NB_IN-1], so a sample >= 0 gives 1 and a negative sample gives 0.
  - o_rx_bit and o_rx_valid are registered and appear one cycle after dec.
- Reference line:
  - On i_ref_valid, ref[0] <= i_ref_bit and ref[k] <= ref[k-1].
  - At dec, the comparison uses ref[o_latency] as held before any same-cycle shift.
  - mismatch = bit XOR ref[o_latency].
- FSM SEARCH:
  - On each dec: win_cnt++, and win_err++ if mismatch.
  - When the WINDOW-th decision of a window completes:
    - if total window errors (including the current one) == 0, go to LOCK;
    - otherwise o_latency <= o_latency+1, wrapping MAX_LAT-1 to 0.
  - win_cnt and win_err clear at every window end.
  - Counters do not advance in SEARCH.
- FSM LOCK:
  - On each dec: o_bit_count++, and o_err_count++ if mismatch.
  - Both counters saturate at all-ones.
  - Window counters keep running. At window end, if window errors > ERR_THR, go to SEARCH with o_latency+1.
  - Counters hold their values on loss of lock; they are not cleared.
- o_lock is registered and equals (state == LOCK).
- i_clear (synchronous, highest priority over dec):
  - counters, window counters and o_latency go to 0; state goes to SEARCH;
  - ph_cnt and the reference line are preserved.
- Transitions out of LOCK are only to SEARCH.
- Latency to lock is at most MAX_LAT*WINDOW decisions.

Decomposition:
- Shared package rx_pkg holds:
  - state encoding: SEARCH=1'b0, LOCK=1'b1;
  - a clog2 constant function;
  - default values of OS, WINDOW and ERR_THR, shared with the TX PRBS and FIR top level.
- One sub-module, symbol_slicer, contains ph_cnt, the dec strobe and the registered o_rx_bit/o_rx_valid.
- The top module holds the reference line, FSM and counters.

Test Plan:
1. Reset: hold i_reset=0 for 5 cycles with random inputs.
   -> all outputs 0 and o_lock=0. Release reset -> first o_rx_valid occurs OS i_en cycles later at most.
2. Clean lock: PRBS9 loopback through the FIR model with 37-symbol delay, OS=4, i_phase at the eye centre.
   -> o_lock=1 after 38 windows, o_latency=37, o_err_count=0. o_bit_count increments by 1 per symbol.
3. Single error: while locked, invert one received symbol.
   -> o_err_count=1, o_lock stays 1. The following 1000 symbols leave o_err_count=1.
4. Burst / loss: while locked, invert 64 of 128 symbols in one window.
   -> o_lock=0 at window end, o_latency=38, counters held. Restoring the stream relocks at latency 37 after wrap-around (MAX_LAT-1 windows).
5. Clear mid-lock: pulse i_clear while locked.
   -> next cycle counters=0, o_latency=0, o_lock=0. Relock follows as in test 2.
6. Saturation and async reset: override NB_CNT=4 and inject errors continuously.
   -> o_err_count sticks at 15. Asserting i_reset mid-window zeroes all outputs immediately, without waiting for a clk edge.
